// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared encodings and constants for the fetch stage
package instr_fetch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;
    localparam logic [31:0] NOP_ENC = 32'h0000_0013;
    localparam logic [31:0] PC_INC  = 32'd4;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and imem req/ack front end feeding decode with registered outputs
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic        instr_valid
);
    fetch_state_e state_q;
    logic [31:0]  pc_q, req_addr_q, buf_instr_q, buf_pc_q;
    logic [31:0]  instr_q, pc_out_q, next_pc_q;
    logic         valid_q;
    logic [31:0]  target_d, req_next_d;

    assign target_d    = {redirect_pc[31:2], 2'b00};
    assign req_next_d  = req_addr_q + PC_INC;
    assign imem_req    = (state_q == BUSY) || (state_q == DRAIN);
    assign imem_addr   = req_addr_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign next_pc_out = next_pc_q;
    assign instr_valid = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            instr_q     <= NOP_INSTR;
            pc_out_q    <= '0;
            next_pc_q   <= '0;
            valid_q     <= 1'b0;
        end else if (redirect) begin
            // an unacked request must still be retired by memory, so park in DRAIN
            pc_q        <= target_d;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            if (imem_req && !imem_ack) begin
                state_q <= DRAIN;
            end else if (!stall) begin
                state_q    <= BUSY;
                req_addr_q <= target_d;
            end else begin
                state_q <= IDLE;
            end
        end else begin
            case (state_q)
                IDLE: if (!stall) begin
                    req_addr_q <= pc_q;
                    state_q    <= BUSY;
                end
                BUSY: if (imem_ack) begin
                    pc_q <= req_next_d;
                    if (!stall) begin
                        instr_q    <= imem_rdata;
                        pc_out_q   <= req_addr_q;
                        next_pc_q  <= req_next_d;
                        valid_q    <= 1'b1;
                        req_addr_q <= req_next_d;
                    end else begin
                        buf_instr_q <= imem_rdata;
                        buf_pc_q    <= req_addr_q;
                        state_q     <= FULL;
                    end
                end
                FULL: if (!stall) begin
                    instr_q    <= buf_instr_q;
                    pc_out_q   <= buf_pc_q;
                    next_pc_q  <= buf_pc_q + PC_INC;
                    valid_q    <= 1'b1;
                    req_addr_q <= pc_q;
                    state_q    <= BUSY;
                end
                DRAIN: if (imem_ack) begin
                    if (!stall) begin
                        req_addr_q <= pc_q;
                        state_q    <= BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch handshake, stall buffering, redirect and wrap
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc_out, next_pc_out;
    logic [129:0] obs, exp_v;
    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .pc_out(pc_out), .next_pc_out(next_pc_out), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;
    assign obs = {instr, pc_out, next_pc_out, instr_valid, imem_req, imem_addr};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
        step(); step();
        exp_v = {32'h13, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_zero_wait;
        rst = 1'b0;
        step();
        exp_v = {32'h13, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL first_req got %h exp %h", obs, exp_v); end
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = (32'(i) * 4) ^ 32'hA5A5_0000;
            step();
            exp_v = {(32'(i) * 4) ^ 32'hA5A5_0000, 32'(i) * 4, 32'(i) * 4 + 4, 1'b1, 1'b1, 32'(i) * 4 + 4};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL zero_wait%0d got %h exp %h", i, obs, exp_v); end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_slow_mem;
        exp_v = {32'hA5A5_000C, 32'hC, 32'h10, 1'b1, 1'b1, 32'h10};
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL slow_hold%0d got %h exp %h", i, obs, exp_v); end
        end
        imem_ack = 1'b1; imem_rdata = 32'h1111_0010;
        step();
        imem_ack = 1'b0;
        exp_v = {32'h1111_0010, 32'h10, 32'h14, 1'b1, 1'b1, 32'h14};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL slow_ack got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_stall;
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2222_0014;
        step();
        imem_ack = 1'b0;
        exp_v = {32'h1111_0010, 32'h10, 32'h14, 1'b1, 1'b0, 32'h14};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_capture got %h exp %h", obs, exp_v); end
        step();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_hold got %h exp %h", obs, exp_v); end
        stall = 1'b0;
        step();
        exp_v = {32'h2222_0014, 32'h14, 32'h18, 1'b1, 1'b1, 32'h18};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_release got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_redirect_drain;
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        exp_v = {32'h13, 32'h14, 32'h18, 1'b0, 1'b1, 32'h18};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL redir_bubble got %h exp %h", obs, exp_v); end
        step();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL redir_hold got %h exp %h", obs, exp_v); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        exp_v = {32'h13, 32'h14, 32'h18, 1'b0, 1'b1, 32'h100};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL redir_drop got %h exp %h", obs, exp_v); end
        imem_rdata = 32'h3333_0100;
        step();
        imem_ack = 1'b0;
        exp_v = {32'h3333_0100, 32'h100, 32'h104, 1'b1, 1'b1, 32'h104};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL redir_target got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_redirect_ack_stall;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200; imem_ack = 1'b1; imem_rdata = 32'h4444_0104;
        step();
        redirect = 1'b0; imem_ack = 1'b0;
        exp_v = {32'h13, 32'h100, 32'h104, 1'b0, 1'b0, 32'h104};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ras_idle got %h exp %h", obs, exp_v); end
        step();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ras_hold got %h exp %h", obs, exp_v); end
        stall = 1'b0;
        step();
        exp_v = {32'h13, 32'h100, 32'h104, 1'b0, 1'b1, 32'h200};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ras_release got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_wrap;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; imem_ack = 1'b1; imem_rdata = 32'h7777_0200;
        step();
        redirect = 1'b0; imem_rdata = 32'h5555_0000;
        exp_v = {32'h13, 32'h100, 32'h104, 1'b0, 1'b1, 32'hFFFF_FFFC};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_target got %h exp %h", obs, exp_v); end
        step();
        imem_ack = 1'b0;
        exp_v = {32'h5555_0000, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 32'h0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_deliver got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_reset_in_drain;
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        step();
        redirect = 1'b0;
        exp_v = {32'h13, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 32'h0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rd_drain got %h exp %h", obs, exp_v); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_v = {32'h13, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rd_reset got %h exp %h", obs, exp_v); end
        step();
        exp_v = {32'h13, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rd_refetch got %h exp %h", obs, exp_v); end
        imem_ack = 1'b1; imem_rdata = 32'h6666_0000;
        step();
        imem_ack = 1'b0;
        exp_v = {32'h6666_0000, 32'h0, 32'h4, 1'b1, 1'b1, 32'h4};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rd_deliver got %h exp %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_slow_mem();
        test_stall();
        test_redirect_drain();
        test_redirect_ack_stall();
        test_wrap();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
